// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone pipelined arbiter.
//   Master 0 (instruction fetch) and master 1 (load/store) share one bus.
//   Ownership is held for a whole burst. Up to MAX_OUTSTANDING accepted
//   requests may await acknowledgement. A watchdog raises a one-cycle err
//   to the owner if no ack arrives for TIMEOUT_CYCLES cycles.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_mN_wb_*                 master N request (stb, data, addr, we, sel)
//   o_mN_wb_*                 master N response (data, ack, stall, err)
//   o_wb_*                    request forwarded to the bus
//   i_wb_data/ack/stall       bus response
module wb_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // master 0
  input  logic        i_m0_wb_stb,
  input  logic [31:0] i_m0_wb_data,
  input  logic [31:0] i_m0_wb_addr,
  input  logic        i_m0_wb_we,
  input  logic [2:0]  i_m0_wb_sel,
  output logic [31:0] o_m0_wb_data,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_stall,
  output logic        o_m0_wb_err,
  // master 1
  input  logic        i_m1_wb_stb,
  input  logic [31:0] i_m1_wb_data,
  input  logic [31:0] i_m1_wb_addr,
  input  logic        i_m1_wb_we,
  input  logic [2:0]  i_m1_wb_sel,
  output logic [31:0] o_m1_wb_data,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_stall,
  output logic        o_m1_wb_err,
  // bus side
  output logic        o_wb_stb,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] outstanding_q, outstanding_d;
  logic [7:0] timeout_q, timeout_d;
  logic       last_grant_q, last_grant_d;

  logic       owner_id;
  logic       owner_stb;
  logic       owner_stall;
  logic       accept;
  logic       ack_ok;
  logic       expire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      outstanding_q <= '0;
      timeout_q     <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      timeout_q     <= timeout_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    timeout_d     = timeout_q;
    last_grant_d  = last_grant_q;

    o_wb_stb      = 1'b0;
    o_wb_data     = '0;
    o_wb_addr     = '0;
    o_wb_we       = 1'b0;
    o_wb_sel      = '0;

    o_m0_wb_data  = '1;
    o_m1_wb_data  = '1;
    o_m0_wb_ack   = 1'b0;
    o_m1_wb_ack   = 1'b0;
    o_m0_wb_err   = 1'b0;
    o_m1_wb_err   = 1'b0;
    o_m0_wb_stall = 1'b1;
    o_m1_wb_stall = 1'b1;

    owner_id      = 1'b0;
    owner_stb     = 1'b0;
    owner_stall   = 1'b1;
    accept        = 1'b0;
    ack_ok        = 1'b0;
    expire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Nothing can be outstanding here; late bus acks are simply dropped.
        outstanding_d = '0;
        timeout_d     = '0;
        if (i_m0_wb_stb && i_m1_wb_stb) begin
          state_d = last_grant_q ? S_OWN0 : S_OWN1;
        end else if (i_m0_wb_stb) begin
          state_d = S_OWN0;
        end else if (i_m1_wb_stb) begin
          state_d = S_OWN1;
        end
      end

      S_OWN0, S_OWN1: begin
        if (state_q == S_OWN0) begin
          owner_id  = 1'b0;
          owner_stb = i_m0_wb_stb;
          o_wb_data = i_m0_wb_data;
          o_wb_addr = i_m0_wb_addr;
          o_wb_we   = i_m0_wb_we;
          o_wb_sel  = i_m0_wb_sel;
        end else begin
          owner_id  = 1'b1;
          owner_stb = i_m1_wb_stb;
          o_wb_data = i_m1_wb_data;
          o_wb_addr = i_m1_wb_addr;
          o_wb_we   = i_m1_wb_we;
          o_wb_sel  = i_m1_wb_sel;
        end

        o_wb_stb    = owner_stb && (outstanding_q < MAX_OUT);
        accept      = o_wb_stb && !i_wb_stall;
        ack_ok      = i_wb_ack && (outstanding_q != 3'd0);
        // An ack in the expiry cycle clears the watchdog instead of erroring.
        expire      = !ack_ok && (timeout_q == TO_LIM);
        owner_stall = i_wb_stall || (outstanding_q == MAX_OUT);

        outstanding_d = outstanding_q + {2'b00, accept} - {2'b00, ack_ok};
        if (accept || ack_ok || (outstanding_q == 3'd0)) begin
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + 8'd1;
        end

        if (owner_id == 1'b0) begin
          o_m0_wb_data  = i_wb_data;
          o_m0_wb_ack   = ack_ok;
          o_m0_wb_stall = owner_stall;
          o_m0_wb_err   = expire;
        end else begin
          o_m1_wb_data  = i_wb_data;
          o_m1_wb_ack   = ack_ok;
          o_m1_wb_stall = owner_stall;
          o_m1_wb_err   = expire;
        end

        if (expire) begin
          outstanding_d = '0;
          timeout_d     = '0;
          state_d       = S_IDLE;
          last_grant_d  = owner_id;
        end else if (!owner_stb && (outstanding_d == 3'd0)) begin
          state_d      = S_IDLE;
          last_grant_d = owner_id;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam logic [31:0] M0_WDATA = 32'h0000_00C0;

  logic        clk;
  logic        rst;
  logic        stb0, stb1, we1;
  logic [31:0] a0, a1, d1;
  logic [2:0]  sel0, sel1;
  logic [31:0] bdata;
  logic        back, bstall;

  logic [31:0] rd0, rd1;
  logic        ack0, ack1, stall0, stall1, err0, err1;
  logic        wb_stb, wb_we;
  logic [31:0] wb_data, wb_addr;
  logic [2:0]  wb_sel;

  int n_chk;
  int n_fail;

  wb_arbiter #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(255)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_m0_wb_stb  (stb0),
    .i_m0_wb_data (M0_WDATA),
    .i_m0_wb_addr (a0),
    .i_m0_wb_we   (1'b0),
    .i_m0_wb_sel  (sel0),
    .o_m0_wb_data (rd0),
    .o_m0_wb_ack  (ack0),
    .o_m0_wb_stall(stall0),
    .o_m0_wb_err  (err0),
    .i_m1_wb_stb  (stb1),
    .i_m1_wb_data (d1),
    .i_m1_wb_addr (a1),
    .i_m1_wb_we   (we1),
    .i_m1_wb_sel  (sel1),
    .o_m1_wb_data (rd1),
    .o_m1_wb_ack  (ack1),
    .o_m1_wb_stall(stall1),
    .o_m1_wb_err  (err1),
    .o_wb_stb     (wb_stb),
    .o_wb_data    (wb_data),
    .o_wb_addr    (wb_addr),
    .o_wb_we      (wb_we),
    .o_wb_sel     (wb_sel),
    .i_wb_data    (bdata),
    .i_wb_ack     (back),
    .i_wb_stall   (bstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, stb0, stb1, we1;
    logic [31:0] addr0, addr1, wd1;
    logic [2:0]  sel0, sel1;
    logic [31:0] bdata;
    logic        back, bstall;
    logic        e_stb, e_fwd;
    logic [31:0] e_addr;
    logic        e_we;
    logic [2:0]  e_sel;
    logic [31:0] e_wd;
    logic        e_stall0, e_stall1, e_ack0, e_ack1, e_err0, e_err1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vt[$];
  vec_t v;

  function automatic vec_t blank();
    vec_t r;
    r          = '0;
    r.sel0     = 3'b010;
    r.e_stall0 = 1'b1;
    r.e_stall1 = 1'b1;
    r.e_rd0    = 32'hFFFF_FFFF;
    r.e_rd1    = 32'hFFFF_FFFF;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; stb0 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; d1 = '0; sel0 = 3'b010; sel1 = 3'b000;
    bdata = '0; back = 1'b0; bstall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; stb0 = x.stb0; stb1 = x.stb1; we1 = x.we1;
    a0 = x.addr0; a1 = x.addr1; d1 = x.wd1; sel0 = x.sel0; sel1 = x.sel1;
    bdata = x.bdata; back = x.back; bstall = x.bstall;
  endtask

  task automatic check_vec(input vec_t x, input int idx);
    chk($sformatf("v%0d.stb", idx), {31'b0, wb_stb}, {31'b0, x.e_stb});
    chk($sformatf("v%0d.stall0", idx), {31'b0, stall0}, {31'b0, x.e_stall0});
    chk($sformatf("v%0d.stall1", idx), {31'b0, stall1}, {31'b0, x.e_stall1});
    chk($sformatf("v%0d.ack0", idx), {31'b0, ack0}, {31'b0, x.e_ack0});
    chk($sformatf("v%0d.ack1", idx), {31'b0, ack1}, {31'b0, x.e_ack1});
    chk($sformatf("v%0d.err", idx), {30'b0, err1, err0}, {30'b0, x.e_err1, x.e_err0});
    chk($sformatf("v%0d.rd0", idx), rd0, x.e_rd0);
    chk($sformatf("v%0d.rd1", idx), rd1, x.e_rd1);
    if (x.e_fwd) begin
      chk($sformatf("v%0d.addr", idx), wb_addr, x.e_addr);
      chk($sformatf("v%0d.we", idx), {31'b0, wb_we}, {31'b0, x.e_we});
      chk($sformatf("v%0d.sel", idx), {29'b0, wb_sel}, {29'b0, x.e_sel});
      chk($sformatf("v%0d.wdata", idx), wb_data, x.e_wd);
    end
  endtask

  initial begin
    int acc;
    int nack;
    int k;
    logic seen;

    n_chk  = 0;
    n_fail = 0;
    clear_inputs();

    // ---- vector table: one row per clock cycle ----
    // idle after reset
    v = blank(); vt.push_back(v);
    // single fetch m0 @0x100
    v = blank(); v.stb0 = 1; v.addr0 = 32'h100; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.addr0 = 32'h100;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'h100; v.e_sel = 3'b010; v.e_wd = M0_WDATA;
    v.e_stall0 = 0; v.e_rd0 = 32'h0; vt.push_back(v);
    v = blank(); v.back = 1; v.bdata = 32'hDEADBEEF;
    v.e_stall0 = 0; v.e_ack0 = 1; v.e_rd0 = 32'hDEADBEEF; vt.push_back(v);
    v = blank(); v.back = 1; v.bdata = 32'hDEADBEEF; vt.push_back(v);   // idle, ack dropped
    // write pass-through m1
    v = blank(); v.stb1 = 1; v.we1 = 1; v.addr1 = 32'hFFFF_FFF1; v.wd1 = 32'h41; vt.push_back(v);
    v = blank(); v.stb1 = 1; v.we1 = 1; v.addr1 = 32'hFFFF_FFF1; v.wd1 = 32'h41;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'hFFFF_FFF1; v.e_we = 1; v.e_sel = 3'b000; v.e_wd = 32'h41;
    v.e_stall1 = 0; v.e_rd1 = 32'h0; vt.push_back(v);
    v = blank(); v.back = 1; v.bdata = 32'h0000_1234;
    v.e_stall1 = 0; v.e_ack1 = 1; v.e_rd1 = 32'h0000_1234; vt.push_back(v);
    // contention from reset
    v = blank(); v.rst = 1; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.stb1 = 1; v.addr0 = 32'h200; v.addr1 = 32'h300; v.sel1 = 3'b010; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.stb1 = 1; v.addr0 = 32'h200; v.addr1 = 32'h300; v.sel1 = 3'b010;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'h200; v.e_sel = 3'b010; v.e_wd = M0_WDATA;
    v.e_stall0 = 0; v.e_rd0 = 32'h0; vt.push_back(v);
    v = blank(); v.stb1 = 1; v.addr1 = 32'h300; v.sel1 = 3'b010; v.back = 1; v.bdata = 32'hA5A5A5A5;
    v.e_stall0 = 0; v.e_ack0 = 1; v.e_rd0 = 32'hA5A5A5A5; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.stb1 = 1; v.addr0 = 32'h200; v.addr1 = 32'h300; v.sel1 = 3'b010; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.stb1 = 1; v.addr0 = 32'h200; v.addr1 = 32'h300; v.sel1 = 3'b010;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'h300; v.e_sel = 3'b010; v.e_wd = 32'h0;
    v.e_stall1 = 0; v.e_rd1 = 32'h0; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.addr0 = 32'h200; v.back = 1; v.bdata = 32'h5A5A5A5A;
    v.e_stall1 = 0; v.e_ack1 = 1; v.e_rd1 = 32'h5A5A5A5A; vt.push_back(v);
    v = blank(); vt.push_back(v);
    // bus stall not counted, ack with nothing outstanding ignored
    v = blank(); v.stb0 = 1; v.addr0 = 32'h400; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.addr0 = 32'h400; v.bstall = 1; v.back = 1; v.bdata = 32'h11112222;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'h400; v.e_sel = 3'b010; v.e_wd = M0_WDATA;
    v.e_rd0 = 32'h11112222; vt.push_back(v);
    v = blank(); v.stb0 = 1; v.addr0 = 32'h400;
    v.e_stb = 1; v.e_fwd = 1; v.e_addr = 32'h400; v.e_sel = 3'b010; v.e_wd = M0_WDATA;
    v.e_stall0 = 0; v.e_rd0 = 32'h0; vt.push_back(v);
    v = blank(); v.back = 1; v.bdata = 32'h33334444;
    v.e_stall0 = 0; v.e_ack0 = 1; v.e_rd0 = 32'h33334444; vt.push_back(v);
    v = blank(); vt.push_back(v);

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      check_vec(vt[i], i);
    end

    // ---- outstanding cap with m1 ----
    do_reset();
    @(negedge clk);
    stb1 = 1; a1 = 32'h500; sel1 = 3'b010;
    #1 chk("cap.idle_stall1", {31'b0, stall1}, 32'd1);
    acc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      if (wb_stb && !bstall) acc++;
      if (c == 5) chk("cap.stall1_5th", {31'b0, stall1}, 32'd1);
    end
    chk("cap.accepted", acc, 32'd4);
    @(negedge clk);
    back = 1;
    #1;
    chk("cap.ack1", {31'b0, ack1}, 32'd1);
    chk("cap.stb_during_ack", {31'b0, wb_stb}, 32'd0);
    @(negedge clk);
    back = 0;
    #1;
    chk("cap.fifth_stb", {31'b0, wb_stb}, 32'd1);
    chk("cap.fifth_stall1", {31'b0, stall1}, 32'd0);
    @(negedge clk);
    stb1 = 0;
    #1 chk("cap.full_again", {31'b0, stall1}, 32'd1);
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      back = 1;
      #1;
      if (ack1) nack++;
    end
    chk("cap.drain_acks", nack, 32'd4);
    @(negedge clk);
    #1;
    chk("cap.extra_ack_dropped", {31'b0, ack1}, 32'd0);
    chk("cap.idle_after_drain", {31'b0, stall1}, 32'd1);
    back = 0;

    // ---- timeout on m0 ----
    do_reset();
    @(negedge clk);
    stb0 = 1; a0 = 32'h600;
    @(negedge clk);
    #1 chk("to.accept", {31'b0, wb_stb}, 32'd1);
    @(negedge clk);
    stb0 = 0;
    seen = 1'b0;
    k = 1;
    for (int c = 1; c <= 400; c++) begin
      if (!seen) begin
        #1;
        if (err0) begin
          seen = 1'b1;
          k = c;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL to.err_seen: no err0 within 400 cycles, expected after 256");
    end else begin
      chk("to.err_cycle", k, 32'd256);
      chk("to.no_ack_with_err", {31'b0, ack0}, 32'd0);
      @(negedge clk);
      back = 1; bdata = 32'hBAD0BAD0;
      #1;
      chk("to.err_one_cycle", {31'b0, err0}, 32'd0);
      chk("to.late_ack_dropped", {30'b0, ack1, ack0}, 32'd0);
      chk("to.idle_stall0", {31'b0, stall0}, 32'd1);
      chk("to.idle_rd0", rd0, 32'hFFFF_FFFF);
      back = 0;
    end

    // ---- ack at the expiry cycle wins ----
    do_reset();
    @(negedge clk);
    stb0 = 1; a0 = 32'h680;
    @(negedge clk);
    @(negedge clk);
    stb0 = 0;
    repeat (255) @(negedge clk);
    back = 1; bdata = 32'h0BEE_F00D;
    #1;
    chk("race.ack0", {31'b0, ack0}, 32'd1);
    chk("race.no_err", {31'b0, err0}, 32'd0);
    chk("race.rd0", rd0, 32'h0BEE_F00D);
    @(negedge clk);
    back = 0;
    #1;
    chk("race.after_no_err", {31'b0, err0}, 32'd0);
    chk("race.idle_stall0", {31'b0, stall0}, 32'd1);

    // ---- reset mid-burst ----
    do_reset();
    @(negedge clk);
    stb0 = 1; a0 = 32'h700;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst.second_accept", {31'b0, wb_stb}, 32'd1);
    @(negedge clk);
    stb0 = 0; rst = 1;
    @(negedge clk);
    rst = 0; back = 1; bdata = 32'hCAFE_F00D;
    #1;
    chk("rst.stb", {31'b0, wb_stb}, 32'd0);
    chk("rst.stalls", {30'b0, stall1, stall0}, 32'd3);
    chk("rst.acks", {30'b0, ack1, ack0}, 32'd0);
    chk("rst.errs", {30'b0, err1, err0}, 32'd0);
    chk("rst.rd0", rd0, 32'hFFFF_FFFF);
    chk("rst.rd1", rd1, 32'hFFFF_FFFF);
    @(negedge clk);
    stb0 = 1; back = 0;
    @(negedge clk);
    stb0 = 0; back = 1;
    #1 chk("rst.stale_ack_ignored", {31'b0, ack0}, 32'd0);
    @(negedge clk);
    back = 0;
    #1 chk("rst.back_to_idle", {31'b0, stall0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
